epp_slave_if: RTL

Host-side parallel-port slave that terminates the USB controller's EPP-style bus (address strobe, data strobe, write enable, wait) and converts it into single-clock internal register-access strobes. It sits directly upstream of the top-level register file. It owns the bidirectional usbData pad, the address register and the wait handshake. The register file sees only an address, a one-cycle write pulse with captured data, a read-data input and a one-cycle read pulse.

---
 rtl/epp_slave_if_if.sv | 23 ++
 rtl/epp_slave_if.sv | 134 +++++++++++++
 2 files changed

// File: rtl/epp_slave_if_if.sv
// Host-side EPP control signals between the USB controller and epp_slave_if.
// Handshake: the host pulls one strobe low (address or data), holds usbWE_n and any write data
// stable until usbWait goes 1, then raises the strobe; usbWait returns to 0 once the release is seen.
interface epp_slave_if_if;
  logic usbAddrStrobe_n;
  logic usbDataStrobe_n;
  logic usbWE_n;
  logic usbWait;

  modport master (
    output usbAddrStrobe_n,
    output usbDataStrobe_n,
    output usbWE_n,
    input  usbWait
  );

  modport slave (
    input  usbAddrStrobe_n,
    input  usbDataStrobe_n,
    input  usbWE_n,
    output usbWait
  );
endinterface

// File: rtl/epp_slave_if.sv
// EPP-style parallel-port slave: synchronizes host strobes, owns the usbData pad and the
// address register, and turns host cycles into single-clock register-file strobes.
module epp_slave_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  epp_slave_if_if.slave         host,
  inout  wire  [DATA_WIDTH-1:0] usbData,
  output logic [ADDR_WIDTH-1:0] usbIF_address,
  output logic                  usbIF_data_write,
  output logic [DATA_WIDTH-1:0] usbIF_data_out,
  input  logic [DATA_WIDTH-1:0] usbIF_data_in,
  output logic                  usbIF_data_read,
  output logic                  o_dbg_state,
  output logic                  o_dbg_drive_en
);

  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_as_sync, r_ds_sync, r_we_sync;
  logic                  w_as, w_ds, w_we;
  logic                  r_act_addr, w_act_addr_nxt;
  logic                  w_act_high;
  logic                  r_wait, w_wait_nxt;
  logic                  r_drive_en, w_drive_en_nxt;
  logic [DATA_WIDTH-1:0] r_rd, w_rd_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_dout, w_dout_nxt;
  logic                  r_wr_pulse, w_wr_pulse_nxt;
  logic                  r_rd_pulse, w_rd_pulse_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_as_sync <= 2'b11;
      r_ds_sync <= 2'b11;
      r_we_sync <= 2'b11;
    end else begin
      r_as_sync <= {r_as_sync[0], host.usbAddrStrobe_n};
      r_ds_sync <= {r_ds_sync[0], host.usbDataStrobe_n};
      r_we_sync <= {r_we_sync[0], host.usbWE_n};
    end
  end

  assign w_as       = r_as_sync[1];
  assign w_ds       = r_ds_sync[1];
  assign w_we       = r_we_sync[1];
  assign w_act_high = r_act_addr ? w_as : w_ds;

  // The pad is sampled raw: the host keeps it stable across the synchronizer delay.
  always_comb begin
    w_state_nxt    = r_state;
    w_act_addr_nxt = r_act_addr;
    w_wait_nxt     = r_wait;
    w_drive_en_nxt = r_drive_en;
    w_rd_nxt       = r_rd;
    w_addr_nxt     = r_addr;
    w_dout_nxt     = r_dout;
    w_wr_pulse_nxt = 1'b0;
    w_rd_pulse_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_as && w_ds) begin
          w_state_nxt    = S_ACK;
          w_act_addr_nxt = 1'b1;
          if (!w_we) begin
            w_addr_nxt = usbData[ADDR_WIDTH-1:0];
          end else begin
            w_rd_nxt       = DATA_WIDTH'(r_addr);
            w_drive_en_nxt = 1'b1;
          end
        end else if (w_as && !w_ds) begin
          w_state_nxt    = S_ACK;
          w_act_addr_nxt = 1'b0;
          if (!w_we) begin
            w_dout_nxt     = usbData;
            w_wr_pulse_nxt = 1'b1;
          end else begin
            w_rd_nxt       = usbIF_data_in;
            w_drive_en_nxt = 1'b1;
            w_rd_pulse_nxt = 1'b1;
          end
        end
      end
      S_ACK: begin
        // Wait rises one edge after capture and drops on the edge the release is seen.
        if (w_act_high) begin
          w_state_nxt    = S_IDLE;
          w_wait_nxt     = 1'b0;
          w_drive_en_nxt = 1'b0;
        end else begin
          w_wait_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_act_addr <= 1'b0;
      r_wait     <= 1'b0;
      r_drive_en <= 1'b0;
      r_rd       <= '0;
      r_addr     <= '0;
      r_dout     <= '0;
      r_wr_pulse <= 1'b0;
      r_rd_pulse <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_act_addr <= w_act_addr_nxt;
      r_wait     <= w_wait_nxt;
      r_drive_en <= w_drive_en_nxt;
      r_rd       <= w_rd_nxt;
      r_addr     <= w_addr_nxt;
      r_dout     <= w_dout_nxt;
      r_wr_pulse <= w_wr_pulse_nxt;
      r_rd_pulse <= w_rd_pulse_nxt;
    end
  end

  assign usbData          = r_drive_en ? r_rd : {DATA_WIDTH{1'bz}};
  assign host.usbWait     = r_wait;
  assign usbIF_address    = r_addr;
  assign usbIF_data_out   = r_dout;
  assign usbIF_data_write = r_wr_pulse;
  assign usbIF_data_read  = r_rd_pulse;
  assign o_dbg_state      = (r_state == S_ACK);
  assign o_dbg_drive_en   = r_drive_en;

endmodule
